spi_ram_responder: RTL

SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

---
 rtl/spi_ram_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_responder.sv
// SPI mode-0 byte-RAM responder: READ (0x03) / WRITE (0x02) with 24-bit address and auto-increment.
// Optional debug read port enabled by defining SPI_RAM_DEBUG_PORT_EN.
module spi_ram_responder #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_clk,
    input  logic                 spi_select,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe
`ifdef SPI_RAM_DEBUG_PORT_EN
    ,
    input  logic [ADDR_BITS-1:0] debug_addr,
    output logic [7:0]           debug_data
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic                 sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic                 sel_meta_r, sel_sync_r, sel_prev_r;
    logic                 mosi_meta_r, mosi_sync_r;

    logic [2:0]           state_r;
    logic [4:0]           bit_cnt_r;
    logic [6:0]           shift_r;
    logic [6:0]           tx_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic                 cmd_read_r;
    logic                 rd_loaded_r;
    logic                 miso_r;
    logic                 oe_r;

    logic [7:0]           mem_r [DEPTH];

    logic                 sclk_rise_s, sclk_fall_s, sel_fall_s;
    logic                 byte_done_s, mem_we_s;
    logic [7:0]           rx_byte_s, rd_byte_s;
    logic [ADDR_BITS-1:0] rd_addr_s;

    // Two-flop synchronizers plus one history flop for edge detection; reset to bus-idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            sel_meta_r  <= 1'b1;
            sel_sync_r  <= 1'b1;
            sel_prev_r  <= 1'b1;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            sclk_meta_r <= spi_clk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            sel_meta_r  <= spi_select;
            sel_sync_r  <= sel_meta_r;
            sel_prev_r  <= sel_sync_r;
            mosi_meta_r <= spi_mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
    assign sel_fall_s  = ~sel_sync_r & sel_prev_r;
    assign rx_byte_s   = {shift_r, mosi_sync_r};
    assign byte_done_s = sclk_rise_s & (bit_cnt_r == 5'd7);
    assign mem_we_s    = (state_r == ST_WRITE) & ~sel_sync_r & ~sel_fall_s & byte_done_s;
    // The first load in READ uses the address just shifted in; later loads use the next one.
    assign rd_addr_s   = rd_loaded_r ? (addr_r + ADDR_ONE) : addr_r;
    assign rd_byte_s   = mem_r[rd_addr_s];

    // Transaction FSM: command decode, address shift, read shift-out and write byte assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 5'd0;
            shift_r     <= 7'd0;
            tx_r        <= 7'd0;
            addr_r      <= {ADDR_BITS{1'b0}};
            cmd_read_r  <= 1'b0;
            rd_loaded_r <= 1'b0;
            miso_r      <= 1'b0;
            oe_r        <= 1'b0;
        end else if (sel_fall_s || sel_sync_r) begin
            state_r     <= sel_fall_s ? ST_CMD : ST_IDLE;
            bit_cnt_r   <= 5'd0;
            shift_r     <= 7'd0;
            tx_r        <= 7'd0;
            rd_loaded_r <= 1'b0;
            miso_r      <= 1'b0;
            oe_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_r <= rx_byte_s[6:0];
                        if (bit_cnt_r == 5'd7) begin
                            bit_cnt_r  <= 5'd0;
                            cmd_read_r <= (rx_byte_s == 8'h03);
                            if (rx_byte_s == 8'h03 || rx_byte_s == 8'h02) begin
                                state_r <= ST_ADDR;
                            end else begin
                                state_r <= ST_IGNORE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        addr_r <= {addr_r[ADDR_BITS-2:0], mosi_sync_r};
                        if (bit_cnt_r == 5'd23) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= cmd_read_r ? ST_READ : ST_WRITE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_fall_s) begin
                        if (!rd_loaded_r || bit_cnt_r == 5'd7) begin
                            tx_r        <= rd_byte_s[6:0];
                            miso_r      <= rd_byte_s[7];
                            oe_r        <= 1'b1;
                            bit_cnt_r   <= 5'd0;
                            rd_loaded_r <= 1'b1;
                            if (rd_loaded_r) begin
                                addr_r <= addr_r + ADDR_ONE;
                            end
                        end else begin
                            tx_r      <= {tx_r[5:0], 1'b0};
                            miso_r    <= tx_r[6];
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise_s) begin
                        shift_r <= rx_byte_s[6:0];
                        if (bit_cnt_r == 5'd7) begin
                            bit_cnt_r <= 5'd0;
                            addr_r    <= addr_r + ADDR_ONE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                    state_r <= ST_IGNORE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Byte array: no reset, written once per completed WRITE byte at the current address.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= rx_byte_s;
        end
    end

`ifdef SPI_RAM_DEBUG_PORT_EN
    // Registered debug read; a same-cycle SPI write to the address yields the old byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debug_data <= 8'h00;
        end else begin
            debug_data <= mem_r[debug_addr];
        end
    end
`endif

    assign spi_miso    = miso_r;
    assign spi_miso_oe = oe_r;

endmodule
